// File: rtl/sdm_pkg.sv
// Shared types and helpers for the second-order sigma-delta modulator.
// Width defaults, LFSR constants, FSM encoding and the integrator clamp.
package sdm_pkg;

    localparam int          SDM_DW     = 24;
    localparam int          SDM_IW     = 28;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } sdm_state_e;

    // Full-scale magnitude for a dw-bit two's-complement input.
    function automatic logic signed [63:0] sdm_fs(input int dw);
        return 64'sd1 <<< (dw - 1);
    endfunction

    // Clamp v to the range of an iw-bit signed integrator.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int iw);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (iw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (iw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/sdm_lfsr16.sv
// 16-bit Fibonacci LFSR used as the dither source; reseeds on reset.
module sdm_lfsr16
    import sdm_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            state <= LFSR_SEED;
        else if (adv)
            state <= {state[14:0], ^(state & LFSR_TAPS)};
    end

endmodule

// File: rtl/sdm2_modulator.sv
// Second-order 1-bit sigma-delta modulator with dither, integrator clamping
// and an overload-recovery FSM that parks the loop for four updates.
module sdm2_modulator
    import sdm_pkg::*;
#(
    parameter int DW      = SDM_DW,
    parameter int IW      = SDM_IW,
    parameter int OVL_TH  = 2**26,
    parameter int OVL_CNT = 16,
    parameter int DITH_SH = 6
) (
    input  logic          clock,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic          din_valid,
    input  logic          mod_en,
    input  logic          sdm_en,
    input  logic          dither_en,
    input  logic          ovl_clr,
    output logic          sdm_out,
    output logic          ovl_flag,
    output logic          busy_recover
);

    localparam int CW = $clog2(OVL_CNT + 1);
    localparam logic signed [IW+1:0] FS_W     = (IW+2)'(sdm_fs(DW));
    localparam logic signed [IW+1:0] OVL_TH_W = (IW+2)'(OVL_TH);

    sdm_state_e           state, state_nxt;
    logic signed [DW-1:0] x_reg;
    logic signed [IW-1:0] i1, i2, i1_nxt, i2_nxt, i1_upd, i2_upd;
    logic signed [IW+1:0] fb, d_w, s1, s2, i2_abs;
    logic [CW-1:0]        ovl_cnt, ovl_cnt_nxt;
    logic [1:0]           rec_cnt, rec_cnt_nxt;
    logic [15:0]          lfsr;
    logic                 y, over, sdm_out_nxt, ovl_set, lfsr_adv, lfsr_unused;

    sdm_lfsr16 u_lfsr (
        .clock (clock),
        .rst   (rst),
        .adv   (lfsr_adv),
        .state (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:DITH_SH];

    // Loop datapath: sums carried two bits wider than the integrators, then clamped.
    always_comb begin
        y      = ~i2[IW-1];
        fb     = y ? FS_W : -FS_W;
        d_w    = dither_en ? (IW+2)'($signed(lfsr[DITH_SH-1:0])) : '0;
        s1     = (IW+2)'(i1) + (IW+2)'(x_reg) - fb;
        s2     = (IW+2)'(i2) + (IW+2)'(i1) - (fb <<< 1) + d_w;
        i1_upd = IW'(sat_w(64'(s1), IW));
        i2_upd = IW'(sat_w(64'(s2), IW));
        i2_abs = i2_upd[IW-1] ? -(IW+2)'(i2_upd) : (IW+2)'(i2_upd);
        over   = i2_abs > OVL_TH_W;
    end

    always_comb begin
        state_nxt   = state;
        i1_nxt      = i1;
        i2_nxt      = i2;
        sdm_out_nxt = sdm_out;
        ovl_cnt_nxt = ovl_cnt;
        rec_cnt_nxt = rec_cnt;
        ovl_set     = 1'b0;
        lfsr_adv    = 1'b0;
        if (mod_en) begin
            unique case (state)
                IDLE: begin
                    i1_nxt      = '0;
                    i2_nxt      = '0;
                    ovl_cnt_nxt = '0;
                    rec_cnt_nxt = '0;
                    sdm_out_nxt = ~sdm_out;
                    if (sdm_en) state_nxt = RUN;
                end
                RUN: begin
                    lfsr_adv = 1'b1;
                    if (!sdm_en) begin
                        state_nxt   = IDLE;
                        i1_nxt      = '0;
                        i2_nxt      = '0;
                        ovl_cnt_nxt = '0;
                    end else begin
                        sdm_out_nxt = y;
                        i1_nxt      = i1_upd;
                        i2_nxt      = i2_upd;
                        if (!over) begin
                            ovl_cnt_nxt = '0;
                        end else if (ovl_cnt == CW'(OVL_CNT - 1)) begin
                            state_nxt   = RECOVER;
                            ovl_set     = 1'b1;
                            ovl_cnt_nxt = '0;
                            rec_cnt_nxt = '0;
                            i1_nxt      = '0;
                            i2_nxt      = '0;
                        end else begin
                            ovl_cnt_nxt = ovl_cnt + 1'b1;
                        end
                    end
                end
                RECOVER: begin
                    i1_nxt = '0;
                    i2_nxt = '0;
                    if (!sdm_en) begin
                        state_nxt = IDLE;
                    end else begin
                        sdm_out_nxt = ~sdm_out;
                        rec_cnt_nxt = rec_cnt + 2'd1;
                        if (rec_cnt == 2'd3) begin
                            state_nxt   = RUN;
                            ovl_cnt_nxt = '0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x_reg    <= '0;
            i1       <= '0;
            i2       <= '0;
            sdm_out  <= 1'b0;
            ovl_flag <= 1'b0;
            ovl_cnt  <= '0;
            rec_cnt  <= '0;
        end else begin
            if (din_valid) x_reg <= $signed(data_in);
            state   <= state_nxt;
            i1      <= i1_nxt;
            i2      <= i2_nxt;
            sdm_out <= sdm_out_nxt;
            ovl_cnt <= ovl_cnt_nxt;
            rec_cnt <= rec_cnt_nxt;
            // a same-cycle set beats the clear
            if (ovl_set)      ovl_flag <= 1'b1;
            else if (ovl_clr) ovl_flag <= 1'b0;
        end
    end

    assign busy_recover = (state == RECOVER);

endmodule

// File: tb/tb_sdm2_modulator.sv
// Self-checking bench for sdm2_modulator against an arithmetic reference model.
module tb_sdm2_modulator;

    localparam longint FS    = 64'sd1 <<< 23;
    localparam longint I_MAX = (64'sd1 <<< 27) - 1;
    localparam longint I_MIN = -(64'sd1 <<< 27);

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data_in = '0;
    logic        din_valid = 1'b0, mod_en = 1'b0, sdm_en = 1'b0;
    logic        dither_en = 1'b0, ovl_clr = 1'b0;
    logic        sdm_out, ovl_flag, busy_recover;
    logic        sdm_out_o, ovl_flag_o, busy_o;

    int checks = 0;
    int errors = 0;

    longint    m_i1, m_i2, m_x;
    bit [15:0] m_lfsr;
    bit        m_y;

    sdm2_modulator dut (
        .clock(clock), .rst(rst), .data_in(data_in), .din_valid(din_valid),
        .mod_en(mod_en), .sdm_en(sdm_en), .dither_en(dither_en), .ovl_clr(ovl_clr),
        .sdm_out(sdm_out), .ovl_flag(ovl_flag), .busy_recover(busy_recover)
    );

    sdm2_modulator #(.OVL_TH(2**23), .OVL_CNT(1)) dut_ovl (
        .clock(clock), .rst(rst), .data_in(data_in), .din_valid(din_valid),
        .mod_en(mod_en), .sdm_en(sdm_en), .dither_en(dither_en), .ovl_clr(ovl_clr),
        .sdm_out(sdm_out_o), .ovl_flag(ovl_flag_o), .busy_recover(busy_o)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic longint clamp(input longint v);
        if (v > I_MAX) return I_MAX;
        if (v < I_MIN) return I_MIN;
        return v;
    endfunction

    function automatic bit [15:0] lfsr_step(input bit [15:0] s);
        int taps [4] = '{16, 14, 13, 11};
        bit f = 1'b0;
        foreach (taps[k]) f ^= s[taps[k]-1];
        return {s[14:0], f};
    endfunction

    // One modulator update from the difference equations.
    task automatic model_update(input bit dith);
        longint fbv, d, n1, n2;
        m_y = (m_i2 >= 0);
        fbv = m_y ? FS : -FS;
        d   = 0;
        if (dith) begin
            d = longint'(m_lfsr[5:0]);
            if (m_lfsr[5]) d -= 64;
        end
        n1 = clamp(m_i1 + m_x - fbv);
        n2 = clamp(m_i2 + m_i1 - 2 * fbv + d);
        m_i1   = n1;
        m_i2   = n2;
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {din_valid, mod_en, sdm_en, dither_en, ovl_clr} = '0;
        data_in = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Load x_reg with mod_en low, then pass IDLE -> RUN in one mod_en tick.
    task automatic enter_run(input logic [23:0] x);
        din_valid = 1'b1;
        data_in   = x;
        mod_en    = 1'b0;
        tick();
        din_valid = 1'b0;
        sdm_en    = 1'b1;
        mod_en    = 1'b1;
        tick();
        m_i1   = 0;
        m_i2   = 0;
        m_x    = longint'($signed(x));
        m_lfsr = 16'hACE1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (sdm_out !== 1'b0) begin
            errors++; $display("FAIL reset_sdm_out: got %b expected 0", sdm_out);
        end
        checks++;
        if (ovl_flag !== 1'b0) begin
            errors++; $display("FAIL reset_ovl_flag: got %b expected 0", ovl_flag);
        end
        checks++;
        if (busy_recover !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy_recover);
        end
    endtask

    task automatic test_idle_tone();
        do_reset();
        sdm_en = 1'b0;
        mod_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (sdm_out !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL idle_tone[%0d]: got %b expected %b", k, sdm_out, (k % 2 == 0));
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sdm_out !== 1'b0) begin
            errors++; $display("FAIL idle_async_reset: got %b expected 0", sdm_out);
        end
    endtask

    task automatic test_zero_input();
        bit     exp_y  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        longint exp_i1 [4] = '{-FS, 0, FS, 0};
        longint exp_i2 [4] = '{-2*FS, -FS, FS, 0};
        do_reset();
        enter_run(24'h000000);
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (sdm_out !== exp_y[k % 4]) begin
                errors++; $display("FAIL zero_bit[%0d]: got %b expected %b", k, sdm_out, exp_y[k % 4]);
            end
            checks++;
            if (longint'(dut.i1) !== exp_i1[k % 4]) begin
                errors++; $display("FAIL zero_i1[%0d]: got %0d expected %0d", k, longint'(dut.i1), exp_i1[k % 4]);
            end
            checks++;
            if (longint'(dut.i2) !== exp_i2[k % 4]) begin
                errors++; $display("FAIL zero_i2[%0d]: got %0d expected %0d", k, longint'(dut.i2), exp_i2[k % 4]);
            end
        end
    endtask

    task automatic test_dc_half();
        int ones = 0;
        int mism = 0;
        do_reset();
        enter_run(24'h400000);
        for (int k = 0; k < 64 + 1024; k++) begin
            tick();
            model_update(1'b0);
            if (sdm_out !== m_y) mism++;
            if (k >= 64 && sdm_out === 1'b1) ones++;
        end
        checks++;
        if (mism !== 0) begin
            errors++; $display("FAIL dc_bitstream: %0d bits differ from model, expected 0", mism);
        end
        checks++;
        if (ones < 766 || ones > 770) begin
            errors++; $display("FAIL dc_density: got %0d ones expected 768+-2", ones);
        end
        checks++;
        if (ovl_flag !== 1'b0) begin
            errors++; $display("FAIL dc_no_overload: got %b expected 0", ovl_flag);
        end
    endtask

    task automatic test_din_mod_coincide();
        do_reset();
        enter_run(24'h000000);
        repeat (2) begin
            tick();
            model_update(1'b0);
        end
        data_in   = 24'h400000;
        din_valid = 1'b1;
        tick();
        model_update(1'b0);
        m_x = longint'($signed(24'h400000));
        din_valid = 1'b0;
        checks++;
        if (longint'(dut.i1) !== m_i1) begin
            errors++; $display("FAIL coincide_old_x: i1 got %0d expected %0d", longint'(dut.i1), m_i1);
        end
        tick();
        model_update(1'b0);
        checks++;
        if (longint'(dut.i1) !== m_i1) begin
            errors++; $display("FAIL coincide_new_x: i1 got %0d expected %0d", longint'(dut.i1), m_i1);
        end
    endtask

    task automatic test_overload();
        int pulses = 0;
        int n = 0;
        do_reset();
        enter_run(24'h000000);
        tick();
        checks++;
        if (busy_o !== 1'b1 || ovl_flag_o !== 1'b1) begin
            errors++; $display("FAIL ovl_trigger: busy=%b flag=%b expected 1 1", busy_o, ovl_flag_o);
        end
        while (busy_o === 1'b1 && n < 200) begin
            mod_en = 1'($urandom_range(0, 1));
            if (mod_en) pulses++;
            tick();
            n++;
        end
        checks++;
        if (n >= 200 || pulses !== 4) begin
            errors++; $display("FAIL ovl_recover_len: %0d mod_en pulses in %0d cycles, expected 4", pulses, n);
        end
        mod_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (ovl_flag_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL ovl_sticky: flag=%b busy=%b expected 1 0", ovl_flag_o, busy_o);
        end
        ovl_clr = 1'b1;
        tick();
        checks++;
        if (ovl_flag_o !== 1'b0) begin
            errors++; $display("FAIL ovl_clear: got %b expected 0", ovl_flag_o);
        end
        mod_en = 1'b1;
        tick();
        checks++;
        if (ovl_flag_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++; $display("FAIL ovl_set_beats_clear: flag=%b busy=%b expected 1 1", ovl_flag_o, busy_o);
        end
        checks++;
        if (ovl_flag !== 1'b0) begin
            errors++; $display("FAIL ovl_default_quiet: got %b expected 0", ovl_flag);
        end
        ovl_clr = 1'b0;
        mod_en  = 1'b0;
        rst     = 1'b1;
        #1;
        checks++;
        if (ovl_flag_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL ovl_async_reset: flag=%b busy=%b expected 0 0", ovl_flag_o, busy_o);
        end
    endtask

    task automatic test_dither();
        int ones = 0;
        int mism = 0;
        do_reset();
        dither_en = 1'b1;
        enter_run(24'h000000);
        for (int k = 0; k < 4096; k++) begin
            tick();
            model_update(1'b1);
            if (sdm_out !== m_y) mism++;
            if (sdm_out === 1'b1) ones++;
            if (k == 9) begin
                checks++;
                if (dut.lfsr !== m_lfsr) begin
                    errors++; $display("FAIL lfsr_10: got %h expected %h", dut.lfsr, m_lfsr);
                end
            end
        end
        checks++;
        if (mism !== 0) begin
            errors++; $display("FAIL dither_bitstream: %0d bits differ from model, expected 0", mism);
        end
        checks++;
        if (ones < 2008 || ones > 2088) begin
            errors++; $display("FAIL dither_density: got %0d ones of 4096 expected 2008..2088", ones);
        end
        checks++;
        if (ovl_flag !== 1'b0) begin
            errors++; $display("FAIL dither_no_overload: got %b expected 0", ovl_flag);
        end
    endtask

    initial begin
        test_reset();
        test_idle_tone();
        test_zero_input();
        test_dc_half();
        test_din_mod_coincide();
        test_overload();
        test_dither();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
